// File: rtl/bpu_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : bpu_update_sched
// Purpose  : Round-robin merge of commit-port branch updates into a small FIFO
//            feeding the BPU, plus a one-index-per-cycle BTB invalidate sweep.
// Options  : define BPU_SCHED_STATS_EN to build the update/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module bpu_update_sched #(
    parameter int XLEN        = 64,
    parameter int NUM_REQ     = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int BTB_ENTRIES = 8192
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*XLEN-1:0]        req_pc,
    input  logic [NUM_REQ*XLEN-1:0]        req_target,
    input  logic [NUM_REQ-1:0]             req_taken,
    input  logic [NUM_REQ-1:0]             req_is_call,
    input  logic [NUM_REQ-1:0]             req_is_ret,
    input  logic                           upd_stall,
    output logic                           update_en,
    output logic [XLEN-1:0]                update_pc,
    output logic [XLEN-1:0]                update_target,
    output logic                           update_taken,
    output logic                           is_call,
    output logic                           is_ret,
    output logic [XLEN-1:0]                ret_addr,
    input  logic                           flush_req,
    output logic                           btb_inval_en,
    output logic [$clog2(BTB_ENTRIES)-1:0] btb_inval_idx,
    output logic                           flush_busy,
    output logic                           flush_done,
    output logic [31:0]                    stat_updates,
    output logic [31:0]                    stat_stalls
);

    localparam int c_RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_IDX_W = $clog2(BTB_ENTRIES);

    localparam logic [c_RR_W:0]    c_NUM_REQ  = (c_RR_W+1)'(NUM_REQ);
    localparam logic [c_RR_W-1:0]  c_LAST_REQ = c_RR_W'(NUM_REQ - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BTB_ENTRIES - 1);

    localparam logic [0:0] c_S_RUN   = 1'b0;
    localparam logic [0:0] c_S_SWEEP = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            call;
        logic            ret;
    } upd_entry_t;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_RR_W-1:0]  r_rr_ptr;
    logic [NUM_REQ-1:0] w_valid_rot;
    logic               w_found;
    logic [c_RR_W:0]    w_grant_sum;
    logic [c_RR_W-1:0]  w_grant_idx;
    logic               w_accept_ok;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_flush_start;
    upd_entry_t         w_push_entry;
    upd_entry_t         w_head;
    upd_entry_t         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_empty;
    logic               w_full;
    logic [c_IDX_W-1:0] r_sweep_idx;
    logic               w_sweep_last;
    logic               r_flush_done;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // Rotate so bit 0 is the requester currently holding top priority.
    assign w_valid_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_found     = 1'b0;
        w_grant_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) begin
                w_found     = 1'b1;
                w_grant_sum = {1'b0, r_rr_ptr} + (c_RR_W+1)'(k);
            end
        end
        if (w_grant_sum >= c_NUM_REQ) begin
            w_grant_sum = w_grant_sum - c_NUM_REQ;
        end
    end

    assign w_grant_idx = w_grant_sum[c_RR_W-1:0];
    assign w_accept_ok = !rst && (r_state == c_S_RUN) && !flush_req && !w_full;
    assign w_ready     = (w_accept_ok && w_found) ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_push      = |(req_valid & w_ready);
    assign req_ready   = w_ready;

    always_comb begin
        w_push_entry = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_ready[k]) begin
                w_push_entry.pc     = req_pc[k*XLEN +: XLEN];
                w_push_entry.target = req_target[k*XLEN +: XLEN];
                w_push_entry.taken  = req_taken[k];
                w_push_entry.call   = req_is_call[k];
                w_push_entry.ret    = req_is_ret[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_grant_idx == c_LAST_REQ) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_RUN:   if (flush_req) w_state_nxt = c_S_SWEEP;
            c_S_SWEEP: if (r_sweep_idx == c_LAST_IDX) w_state_nxt = c_S_RUN;
            default:   w_state_nxt = c_S_RUN;
        endcase
    end

    always_comb begin
        update_en    = 1'b0;
        btb_inval_en = 1'b0;
        flush_busy   = 1'b0;
        if (!rst) begin
            case (r_state)
                c_S_RUN:   update_en = !w_empty && !upd_stall && !flush_req;
                c_S_SWEEP: begin
                    btb_inval_en = 1'b1;
                    flush_busy   = 1'b1;
                end
                default:   update_en = 1'b0;
            endcase
        end
    end

    assign w_pop         = update_en;
    assign w_flush_start = (r_state == c_S_RUN) && flush_req;
    assign w_sweep_last  = (r_state == c_S_SWEEP) && (r_sweep_idx == c_LAST_IDX);

    // ------------------------------------------------------- sweep control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_idx  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= w_sweep_last;
            if (r_state == c_S_SWEEP) begin
                r_sweep_idx <= r_sweep_idx + 1'b1;
            end else begin
                r_sweep_idx <= '0;
            end
        end
    end

    assign btb_inval_idx = r_sweep_idx;
    assign flush_done    = r_flush_done;

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush_start) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_entry;
        end
    end

    // Stale slots are masked so an empty queue always presents zeros.
    assign w_head        = w_empty ? '0 : r_fifo[r_rptr];
    assign update_pc     = w_head.pc;
    assign update_target = w_head.target;
    assign update_taken  = w_head.taken;
    assign is_call       = w_head.call;
    assign is_ret        = w_head.ret;
    assign ret_addr      = w_head.call ? (w_head.pc + XLEN'(4)) : '0;

    // ---------------------------------------------------------- statistics
`ifdef BPU_SCHED_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_stalls;
    logic        w_stall_cycle;

    assign w_stall_cycle = (r_state == c_S_RUN) && !w_empty && upd_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_updates <= '0;
            r_stat_stalls  <= '0;
        end else begin
            if (update_en && (r_stat_updates != 32'hFFFF_FFFF)) begin
                r_stat_updates <= r_stat_updates + 1'b1;
            end
            if (w_stall_cycle && (r_stat_stalls != 32'hFFFF_FFFF)) begin
                r_stat_stalls <= r_stat_stalls + 1'b1;
            end
        end
    end

    assign stat_updates = r_stat_updates;
    assign stat_stalls  = r_stat_stalls;
`else
    assign stat_updates = '0;
    assign stat_stalls  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/bpu_update_sched.md
BPU_UPDATE_SCHED -- requirements
Module: bpu_update_sched

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  XLEN, 64, address width.
  NUM_REQ, 2, update requesters (commit ports).
  FIFO_DEPTH, 4, update queue entries (power of 2).
  BTB_ENTRIES, 8192, BTB index count swept on flush.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, all state on rising edge.
  rst  in  1  synchronous, active-high reset.
  req_valid  in  NUM_REQ  requester i has an update.
  req_ready  out  NUM_REQ  requester i's update accepted this cycle.
  req_pc  in  NUM_REQ*XLEN  branch PC per requester.
  req_target  in  NUM_REQ*XLEN  resolved target per requester.
  req_taken  in  NUM_REQ  resolved direction.
  req_is_call  in  NUM_REQ  branch is a call.
  req_is_ret  in  NUM_REQ  branch is a return.
  upd_stall  in  1  BPU cannot take an update this cycle.
  update_en  out  1  update presented to BPU.
  update_pc, update_target  out  XLEN  update fields.
  update_taken, is_call, is_ret  out  1  update fields.
  ret_addr  out  XLEN  update_pc+4 when is_call, else 0.
  flush_req  in  1  single-cycle request to invalidate the whole BTB.
  btb_inval_en  out  1  invalidate entry btb_inval_idx this cycle.
  btb_inval_idx  out  $clog2(BTB_ENTRIES)  index being invalidated.
  flush_busy  out  1  sweep in progress.
  flush_done  out  1  one-cycle pulse after the last index.
  stat_updates, stat_stalls  out  32  counters (see Configuration).

Function
REQ-003 SHALL implement FSM states RUN and SWEEP; RUN after reset.
REQ-004 In RUN, SHALL grant at most one requester per cycle, round-robin, starting after the last granted index; req_ready[i]=grant_i & FIFO not full; transfer = req_valid[i] & req_ready[i].
REQ-005 req_ready SHALL be 0 for all requesters when FIFO full, in SWEEP, or when flush_req=1.
REQ-006 Accepted updates SHALL enter the FIFO in grant order; the entry pushed at cycle N SHALL be visible on update_* no earlier than cycle N+1.
REQ-007 update_en SHALL be 1 iff state RUN, FIFO not empty, upd_stall=0; update_* SHALL hold the FIFO head; pop occurs when update_en=1.
REQ-008 Push and pop in the same cycle SHALL leave the count unchanged; push when full SHALL never occur.
REQ-009 When is_call=1 with is_ret=1 the entry SHALL be forwarded unchanged; ret_addr = update_pc+4 (mod 2^XLEN) whenever is_call=1.
REQ-010 flush_req in RUN SHALL discard all FIFO contents in that cycle, with no update_en that cycle, and enter SWEEP next cycle with index 0.
REQ-011 In SWEEP, btb_inval_en=1 and flush_busy=1 every cycle, btb_inval_idx counts 0..BTB_ENTRIES-1, one per cycle, ignoring upd_stall.
REQ-012 After index BTB_ENTRIES-1, SHALL return to RUN and pulse flush_done in the first RUN cycle; round-robin pointer SHALL be preserved.
REQ-013 flush_req during SWEEP SHALL be ignored (no restart).
REQ-014 update_en and btb_inval_en SHALL never be 1 together.

Reset
REQ-015 On rst=1: state RUN, FIFO empty, round-robin pointer at requester 0, sweep index 0; update_en, btb_inval_en, flush_busy, flush_done, req_ready, and all update_* fields 0; counters 0.
REQ-016 rst asserted mid-SWEEP SHALL abort the sweep with no flush_done.

Configuration
REQ-017 Macro BPU_SCHED_STATS_EN defined: stat_updates +1 per update_en cycle, stat_stalls +1 per cycle with FIFO non-empty and upd_stall=1 in RUN, both saturating at 32'hFFFF_FFFF; undefined: both outputs tied to 0, no counter flops.

Verification
REQ-018 Bench SHALL cover:
  Both req_valid=1 for 4 cycles, FIFO empty, upd_stall=0 -> grants alternate 0,1,0,1; update_en from cycle 2, same order.
  upd_stall=1, req0 streams 6 updates -> 4 accepted, req_ready[0]=0 while full; release stall -> 4 updates in order, ready reasserts.
  Call at pc=0x1000 -> is_call=1, ret_addr=0x1004; pc=0xFFFF_FFFF_FFFF_FFFC -> ret_addr=0.
  3 entries queued, flush_req -> no update_en, BTB_ENTRIES cycles of btb_inval_en, idx 0..8191, flush_done one cycle, FIFO empty.
  flush_req at sweep index 100 -> sweep continues to 8191 uninterrupted; rst at index 100 -> RUN, outputs 0, no flush_done.
  With BPU_SCHED_STATS_EN, 5 updates and 3 stall cycles -> stat_updates=5, stat_stalls=3; without, both 0.
